// File: rtl/vc_flit_fifo.sv
// vc_flit_fifo: NUM_VC independent flit FIFOs sharing one storage array.
// Each VC owns a 2**DEPTH_LOG2 slice addressed as {vc, ptr}. Pointers carry
// an extra lap bit so full and empty are told apart without a separate count.
// data_o is first-word fall-through for the VC selected by pop_vc.
module vc_flit_fifo #(
  parameter int FLIT_W     = 32,
  parameter int NUM_VC     = 4,
  parameter int VC_W       = 2,
  parameter int DEPTH_LOG2 = 2,
  parameter int AF_LEVEL   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLIT_W-1:0]                data_i,
  input  logic                             push,
  input  logic [VC_W-1:0]                  push_vc,
  input  logic                             pop,
  input  logic [VC_W-1:0]                  pop_vc,
  output logic [FLIT_W-1:0]                data_o,
  output logic [NUM_VC-1:0]                empty,
  output logic [NUM_VC-1:0]                full,
  output logic [NUM_VC-1:0]                almost_full,
  output logic [NUM_VC*(DEPTH_LOG2+1)-1:0] count,
  output logic                             credit_o,
  output logic [VC_W-1:0]                  credit_vc_o,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int AW    = VC_W + DEPTH_LOG2;
  localparam logic [PW-1:0]   AF_CNT = PW'(AF_LEVEL);
  localparam logic [VC_W:0]   VC_LIM = (VC_W+1)'(NUM_VC);

  logic [FLIT_W-1:0]         mem [NUM_VC*DEPTH];
  logic [NUM_VC-1:0][PW-1:0] wptr, rptr, cnt;

  logic          push_ok, pop_ok;
  logic [AW-1:0] waddr, raddr;

  // A VC index beyond NUM_VC is treated like a full/empty queue and rejected.
  assign push_ok = push && ({1'b0, push_vc} < VC_LIM) && !full[push_vc];
  assign pop_ok  = pop  && ({1'b0, pop_vc}  < VC_LIM) && !empty[pop_vc];

  assign waddr  = {push_vc, wptr[push_vc][DEPTH_LOG2-1:0]};
  assign raddr  = {pop_vc,  rptr[pop_vc][DEPTH_LOG2-1:0]};
  assign data_o = mem[raddr];
  assign count  = cnt;

  // Per-VC status derived purely from the lap-bit pointers.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_flags
    assign cnt[v]         = wptr[v] - rptr[v];
    assign empty[v]       = (wptr[v] == rptr[v]);
    assign full[v]        = (wptr[v][DEPTH_LOG2-1:0] == rptr[v][DEPTH_LOG2-1:0]) &&
                            (wptr[v][DEPTH_LOG2] != rptr[v][DEPTH_LOG2]);
    assign almost_full[v] = (cnt[v] >= AF_CNT);
  end

  // Flit storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[waddr] <= data_i;
  end

  // Pointer advance: push and pop act on their own VC independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_ok && push_vc == VC_W'(v)) wptr[v] <= wptr[v] + 1'b1;
        if (pop_ok  && pop_vc  == VC_W'(v)) rptr[v] <= rptr[v] + 1'b1;
      end
    end
  end

  // Credit pulse one cycle after each accepted pop; error flags are sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_o    <= 1'b0;
      credit_vc_o <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      credit_o <= pop_ok;
      if (pop_ok)            credit_vc_o <= pop_vc;
      if (push && !push_ok)  overflow    <= 1'b1;
      if (pop && !pop_ok)    underflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_flit_fifo.sv
// tb_vc_flit_fifo: directed and random scenarios checked against a
// queue-per-VC reference model.
module tb_vc_flit_fifo;
  localparam int FW = 32, NV = 4, VW = 2, DL = 2, AF = 3, PW = DL + 1, D = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [FW-1:0]     data_i;
  logic              push, pop;
  logic [VW-1:0]     push_vc, pop_vc;
  logic [FW-1:0]     data_o;
  logic [NV-1:0]     empty, full, almost_full;
  logic [NV*PW-1:0]  count;
  logic              credit_o;
  logic [VW-1:0]     credit_vc_o;
  logic              overflow, underflow;

  vc_flit_fifo #(.FLIT_W(FW), .NUM_VC(NV), .VC_W(VW), .DEPTH_LOG2(DL), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .push(push), .push_vc(push_vc),
    .pop(pop), .pop_vc(pop_vc), .data_o(data_o), .empty(empty), .full(full),
    .almost_full(almost_full), .count(count), .credit_o(credit_o),
    .credit_vc_o(credit_vc_o), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: one queue per VC plus expected credit / error state.
  logic [FW-1:0] q[NV][$];
  logic          e_ovf = 0, e_unf = 0, e_cr = 0;
  logic [VW-1:0] e_cvc = '0;

  // Drive one cycle from a negedge, update the model at the edge, return at the next negedge.
  task automatic cycle(input logic ps, input logic [VW-1:0] pv, input logic [FW-1:0] d,
                       input logic pp, input logic [VW-1:0] ov);
    bit pok, qok;
    push = ps; push_vc = pv; data_i = d; pop = pp; pop_vc = ov;
    pok = ps && (q[pv].size() < D);
    qok = pp && (q[ov].size() > 0);
    @(posedge clk);
    if (ps && !pok) e_ovf = 1'b1;
    if (pp && !qok) e_unf = 1'b1;
    if (qok) void'(q[ov].pop_front());
    if (pok) q[pv].push_back(d);
    e_cr = qok;
    if (qok) e_cvc = ov;
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic clear_model();
    for (int v = 0; v < NV; v++) q[v].delete();
    e_ovf = 0; e_unf = 0; e_cr = 0; e_cvc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 0; pop = 0; push_vc = '0; pop_vc = '0; data_i = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %h exp %h", empty, 4'hF); end
    n_chk++; if (full !== 4'h0) begin n_fail++; $display("FAIL reset_full got %h exp 0", full); end
    n_chk++; if (almost_full !== 4'h0) begin n_fail++; $display("FAIL reset_af got %h exp 0", almost_full); end
    n_chk++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %h exp 0", count); end
    n_chk++; if (credit_o !== 1'b0 || credit_vc_o !== '0) begin n_fail++; $display("FAIL reset_credit got %b/%0d exp 0/0", credit_o, credit_vc_o); end
    n_chk++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 2'd1, 32'hA0 + i, 0, 2'd0);
      n_chk++; if (count[1*PW +: PW] !== PW'(i + 1)) begin n_fail++; $display("FAIL fill_count%0d got %0d exp %0d", i, count[1*PW +: PW], i + 1); end
      n_chk++; if (almost_full[1] !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_af%0d got %b exp %b", i, almost_full[1], i + 1 >= AF); end
      n_chk++; if (full[1] !== (i == 3)) begin n_fail++; $display("FAIL fill_full%0d got %b exp %b", i, full[1], i == 3); end
    end
    cycle(1, 2'd1, 32'hA4, 0, 2'd0);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_chk++; if (count[1*PW +: PW] !== PW'(4)) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", count[1*PW +: PW]); end
  endtask

  task automatic test_drain_credit();
    for (int i = 0; i < 4; i++) begin
      pop_vc = 2'd1; #1;
      n_chk++; if (data_o !== 32'hA0 + i) begin n_fail++; $display("FAIL drain_data%0d got %h exp %h", i, data_o, 32'hA0 + i); end
      @(negedge clk);
      cycle(0, 2'd0, '0, 1, 2'd1);
      n_chk++; if (credit_o !== 1'b1 || credit_vc_o !== 2'd1) begin n_fail++; $display("FAIL drain_credit%0d got %b/%0d exp 1/1", i, credit_o, credit_vc_o); end
    end
    @(negedge clk);
    n_chk++; if (credit_o !== 1'b0) begin n_fail++; $display("FAIL drain_credit_end got %b exp 0", credit_o); end
    n_chk++; if (empty[1] !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty[1]); end
  endtask

  task automatic test_interleave();
    cycle(1, 2'd0, 32'hB0, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      pop_vc = 2'd0; #1;
      n_chk++; if (data_o !== q[0][0]) begin n_fail++; $display("FAIL il_data%0d got %h exp %h", i, data_o, q[0][0]); end
      @(negedge clk);
      cycle(1, 2'd0, 32'hB1 + i, 1, 2'd0);
      n_chk++; if (count[0 +: PW] !== PW'(1)) begin n_fail++; $display("FAIL il_count0_%0d got %0d exp 1", i, count[0 +: PW]); end
      cycle(1, 2'd3, 32'hC0 + i, 0, 2'd0);
      n_chk++; if (count[3*PW +: PW] !== PW'(i + 1)) begin n_fail++; $display("FAIL il_count3_%0d got %0d exp %0d", i, count[3*PW +: PW], i + 1); end
    end
    pop_vc = 2'd3; #1;
    n_chk++; if (data_o !== 32'hC0) begin n_fail++; $display("FAIL il_vc3_head got %h exp %h", data_o, 32'hC0); end
    @(negedge clk);
  endtask

  task automatic test_underflow();
    cycle(1, 2'd2, 32'hD0, 1, 2'd2);
    n_chk++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b exp 1", underflow); end
    n_chk++; if (credit_o !== 1'b0) begin n_fail++; $display("FAIL unf_credit got %b exp 0", credit_o); end
    n_chk++; if (count[2*PW +: PW] !== PW'(1)) begin n_fail++; $display("FAIL unf_count got %0d exp 1", count[2*PW +: PW]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic          ps, pp;
      logic [VW-1:0] pv, ov;
      logic [FW-1:0] d;
      ps = ($urandom_range(0, 99) < 55); pp = ($urandom_range(0, 99) < 50);
      pv = VW'($urandom_range(0, NV - 1)); ov = VW'($urandom_range(0, NV - 1));
      d = $urandom;
      pop_vc = ov; #1;
      if (q[ov].size() > 0) begin
        n_chk++; if (data_o !== q[ov][0]) begin n_fail++; $display("FAIL rnd_data%0d vc%0d got %h exp %h", n, ov, data_o, q[ov][0]); end
      end
      @(negedge clk);
      cycle(ps, pv, d, pp, ov);
      for (int v = 0; v < NV; v++) begin
        n_chk++;
        if (count[v*PW +: PW] !== PW'(q[v].size()) || empty[v] !== (q[v].size() == 0) ||
            full[v] !== (q[v].size() == D) || almost_full[v] !== (q[v].size() >= AF)) begin
          n_fail++; $display("FAIL rnd_flags%0d vc%0d got cnt %0d e%b f%b af%b exp cnt %0d", n, v,
                             count[v*PW +: PW], empty[v], full[v], almost_full[v], q[v].size());
        end
      end
      n_chk++;
      if (credit_o !== e_cr || (e_cr && credit_vc_o !== e_cvc) || overflow !== e_ovf || underflow !== e_unf) begin
        n_fail++; $display("FAIL rnd_misc%0d got cr %b/%0d o%b u%b exp cr %b/%0d o%b u%b", n,
                           credit_o, credit_vc_o, overflow, underflow, e_cr, e_cvc, e_ovf, e_unf);
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [FW-1:0] exp_q[$];
    // Empty VC0, then prime it with one flit so every later cycle is a push+pop pair.
    while (q[0].size() > 0) cycle(0, 2'd0, '0, 1, 2'd0);
    cycle(1, 2'd0, 32'hE000, 0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      pop_vc = 2'd0; #1;
      n_chk++; if (data_o !== q[0][0]) begin n_fail++; $display("FAIL wrap_data%0d got %h exp %h", i, data_o, q[0][0]); end
      @(negedge clk);
      cycle(1, 2'd0, 32'hE001 + i, 1, 2'd0);
      if (i == 11) begin
        #2 rst = 1'b1; #1;
        n_chk++; if (empty !== 4'hF) begin n_fail++; $display("FAIL midrst_empty got %h exp %h", empty, 4'hF); end
        n_chk++; if (credit_o !== 1'b0) begin n_fail++; $display("FAIL midrst_credit got %b exp 0", credit_o); end
        n_chk++; if (count !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midrst_state got cnt %h o%b u%b exp 0", count, overflow, underflow); end
        clear_model();
        @(negedge clk); rst = 1'b0;
        cycle(1, 2'd0, 32'hF0, 0, 2'd0);
        pop_vc = 2'd0; #1;
        n_chk++; if (data_o !== 32'hF0 || count[0 +: PW] !== PW'(1)) begin n_fail++; $display("FAIL postrst_push got %h/%0d exp f0/1", data_o, count[0 +: PW]); end
        @(negedge clk);
      end
    end
    n_chk++; if (count[0 +: PW] !== PW'(1) || credit_o !== 1'b1) begin n_fail++; $display("FAIL wrap_end got cnt %0d cr %b exp 1/1", count[0 +: PW], credit_o); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_credit();
    test_interleave();
    test_underflow();
    test_random();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
